psec5_cnt_readout_rx: RTL

//  Readout-side partner of the per-channel counter serializer. Runs one frame per START request:
//   - pulses INST_READOUT so the channel snapshots {3'b0, trigger_cnt, CE, CD, CC, CB, CA} (56 b);
//   - loads and shifts out the 7 bytes one at a time via SELECT_REG / LOAD_CNT_SER / CNT_SER;
//   - reassembles and presents the counters plus a DATA_VALID strobe.

---
 rtl/psec5_cnt_readout_rx_if.sv | 32 +++
 rtl/psec5_cnt_readout_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/psec5_cnt_readout_rx_if.sv
// Bus bundle between the counter readout receiver and its environment.
// master: the receiver (drives channel controls and decoded frame outputs).
// slave:  the SPI/readout controller plus the channel serializer.
interface psec5_cnt_readout_rx_if;
    logic       START;
    logic       ABORT;
    logic       CNT_SER;
    logic       INST_READOUT;
    logic       LOAD_CNT_SER;
    logic [2:0] SELECT_REG;
    logic       BUSY;
    logic       DATA_VALID;
    logic [9:0] CA;
    logic [9:0] CB;
    logic [9:0] CC;
    logic [9:0] CD;
    logic [9:0] CE;
    logic [2:0] TRIG_CNT;
    logic       RSVD_ERR;

    modport master (
        input  START, ABORT, CNT_SER,
        output INST_READOUT, LOAD_CNT_SER, SELECT_REG, BUSY, DATA_VALID,
        output CA, CB, CC, CD, CE, TRIG_CNT, RSVD_ERR
    );

    modport slave (
        output START, ABORT, CNT_SER,
        input  INST_READOUT, LOAD_CNT_SER, SELECT_REG, BUSY, DATA_VALID,
        input  CA, CB, CC, CD, CE, TRIG_CNT, RSVD_ERR
    );
endinterface

// File: rtl/psec5_cnt_readout_rx.sv
// PSEC5 per-channel counter readout receiver: snapshots the channel, pulls its
// 7 bytes serially (LSB first) and presents the decoded counters with a strobe.
module psec5_cnt_readout_rx #(
    parameter int unsigned N_BYTES     = 7,
    parameter int unsigned BYTE_W      = 8,
    parameter int unsigned READOUT_GAP = 2
) (
    input logic                     SPI_CLK,
    input logic                     RSTB,
    psec5_cnt_readout_rx_if.master  bus
);

    localparam int unsigned FrameW   = N_BYTES * BYTE_W;
    localparam logic [2:0]  LastByte = 3'(N_BYTES - 1);
    localparam logic [7:0]  GapLast  = 8'(READOUT_GAP - 1);
    localparam logic [2:0]  SelIdle  = 3'd7;

    typedef enum logic [2:0] {StIdle, StRdo, StGap, StLoad, StShift} state_e;

    state_e              state_q, state_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          byte_q, byte_d;
    logic [BYTE_W-1:0]   sbuf_q, sbuf_d;
    logic [FrameW-1:0]   frame_q, frame_d;

    logic                inst_q, inst_d;
    logic                load_q, load_d;
    logic [2:0]          sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                dv_q, dv_d;
    logic [9:0]          ca_q, ca_d, cb_q, cb_d, cc_q, cc_d, cd_q, cd_d, ce_q, ce_d;
    logic [2:0]          trig_q, trig_d;
    logic                rsvd_q, rsvd_d;

    // Next-state and registered-output logic; outputs are computed for the
    // state being entered so every port comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        sbuf_d    = sbuf_q;
        frame_d   = frame_q;
        inst_d    = 1'b0;
        load_d    = 1'b0;
        dv_d      = 1'b0;
        sel_d     = sel_q;
        busy_d    = busy_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        cc_d      = cc_q;
        cd_d      = cd_q;
        ce_d      = ce_q;
        trig_d    = trig_q;
        rsvd_d    = rsvd_q;

        if (bus.ABORT) begin
            state_d = StIdle;
            sel_d   = SelIdle;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    sel_d = SelIdle;
                    if (bus.START) begin
                        state_d = StRdo;
                        inst_d  = 1'b1;
                        busy_d  = 1'b1;
                        sbuf_d  = '0;
                        frame_d = '0;
                        byte_d  = '0;
                    end
                end
                StRdo: begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_d = StLoad;
                        load_d  = 1'b1;
                        byte_d  = '0;
                        sel_d   = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
                StLoad: begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
                StShift: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // First shift cycle carries the serializer's load value; drop it.
                    if (bit_cnt_q != 4'd0) begin
                        sbuf_d = {bus.CNT_SER, sbuf_q[BYTE_W-1:1]};
                    end
                    if (bit_cnt_q == 4'd8) begin
                        frame_d[32'(byte_q) * BYTE_W +: BYTE_W] = sbuf_d;
                        if (byte_q == LastByte) begin
                            // Frame completion is folded into the last shift edge so
                            // the strobe lands in the single IDLE cycle that follows.
                            state_d = StIdle;
                            busy_d  = 1'b0;
                            sel_d   = SelIdle;
                            dv_d    = 1'b1;
                            ca_d    = frame_d[9:0];
                            cb_d    = frame_d[19:10];
                            cc_d    = frame_d[29:20];
                            cd_d    = frame_d[39:30];
                            ce_d    = frame_d[49:40];
                            trig_d  = frame_d[52:50];
                            rsvd_d  = |frame_d[55:53];
                        end else begin
                            state_d = StLoad;
                            byte_d  = byte_q + 3'd1;
                            sel_d   = byte_q + 3'd1;
                            load_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    sel_d   = SelIdle;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            byte_q    <= '0;
            sbuf_q    <= '0;
            frame_q   <= '0;
            inst_q    <= 1'b0;
            load_q    <= 1'b0;
            sel_q     <= SelIdle;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
            ca_q      <= '0;
            cb_q      <= '0;
            cc_q      <= '0;
            cd_q      <= '0;
            ce_q      <= '0;
            trig_q    <= '0;
            rsvd_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            sbuf_q    <= sbuf_d;
            frame_q   <= frame_d;
            inst_q    <= inst_d;
            load_q    <= load_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            dv_q      <= dv_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            cc_q      <= cc_d;
            cd_q      <= cd_d;
            ce_q      <= ce_d;
            trig_q    <= trig_d;
            rsvd_q    <= rsvd_d;
        end
    end

    assign bus.INST_READOUT = inst_q;
    assign bus.LOAD_CNT_SER = load_q;
    assign bus.SELECT_REG   = sel_q;
    assign bus.BUSY         = busy_q;
    assign bus.DATA_VALID   = dv_q;
    assign bus.CA           = ca_q;
    assign bus.CB           = cb_q;
    assign bus.CC           = cc_q;
    assign bus.CD           = cd_q;
    assign bus.CE           = ce_q;
    assign bus.TRIG_CNT     = trig_q;
    assign bus.RSVD_ERR     = rsvd_q;

endmodule
